serial_adder: RTL and testbench

Bit-serial WIDTH-bit adder with carry-in. It is the addition counterpart to the team's full-subtractor-from-half-subtractors datapath. Operands are captured on a start handshake, one full-adder cell is reused LSB-first for WIDTH cycles, and a one-cycle done pulse marks the registered sum and carry-out. It is used wherever area matters more than latency, and it serves as the reference sequential arithmetic block for later serial ALU work.

---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/serial_adder_fa_using_ha.sv | 21 ++
 rtl/serial_adder.sv | 92 +++++++++
 tb/tb_serial_adder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// FSM encoding and constant-width helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_fa_using_ha.sv
// Combinational full adder built from two half adders
// and an OR of their carries.
module fa_using_ha (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;
  logic g1;
  logic g2;

  assign p  = a ^ b;
  assign g1 = a & b;
  assign s  = p ^ ci;
  assign g2 = p & ci;
  assign co = g1 | g2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell reused
// LSB-first, done pulse marks the registered sum/cout.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s;
  logic             c;
  logic             last;
  logic             accept;

  fa_using_ha u_fa (
    .a  (sa[0]),
    .b  (sb[0]),
    .ci (carry),
    .s  (s),
    .co (c)
  );

  assign last   = (cnt == LAST);
  assign accept = start && (state == IDLE || state == DONE);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      sa    <= a;
      sb    <= b;
      carry <= cin;
      res   <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      res   <= {s, res[WIDTH-1:1]};
      carry <= c;
      cnt   <= cnt + 1'b1;
      // final bit: publish result on the RUN->DONE edge
      if (last) begin
        sum  <= {s, res[WIDTH-1:1]};
        cout <= c;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed table-driven bench for serial_adder (WIDTH=8)
// plus an exhaustive WIDTH=4 sweep.
module tb_serial_adder;

  logic       clk = 0;
  logic       rst = 1;
  logic       start8 = 0;
  logic [7:0] a8 = 0;
  logic [7:0] b8 = 0;
  logic       cin8 = 0;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start4 = 0;
  logic [3:0] a4 = 0;
  logic [3:0] b4 = 0;
  logic       cin4 = 0;
  logic       busy4;
  logic       done4;
  logic [3:0] sum4;
  logic       cout4;

  int n_cmp = 0;
  int n_bad = 0;
  logic both_seen = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
  );

  always @(negedge clk)
    if ((busy8 && done8) || (busy4 && done4)) both_seen = 1;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Accept edge then wait for done; lat=0 means timeout.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb,
                     input logic tc, output int lat, output int bc);
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    lat = 0;
    bc = busy8 ? 1 : 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done8) begin lat = k; break; end
      if (busy8) bc++;
    end
  endtask

  task automatic wait_done8(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done8) begin lat = k; break; end
    end
  endtask

  initial begin
    int lat;
    int bc;
    int gap;
    logic [4:0] exp4;

    vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_sum", sum8, 0);
    chk("rst_cout", cout8, 0);

    for (int i = 0; i < 8; i++) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].cin, lat, bc);
      chk($sformatf("v%0d_lat", i), lat, 8);
      chk($sformatf("v%0d_busy", i), bc, 8);
      chk($sformatf("v%0d_sum", i), sum8, vecs[i].sum);
      chk($sformatf("v%0d_cout", i), cout8, vecs[i].cout);
      @(posedge clk); #1;
      chk($sformatf("v%0d_idle", i), {busy8, done8}, 0);
    end

    // start during RUN must be ignored
    a8 = 8'h10; b8 = 8'h20; cin8 = 0; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    repeat (2) @(posedge clk);
    #1;
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    wait_done8(lat);
    chk("ign_lat", lat + 3, 8);
    chk("ign_sum", sum8, 8'h30);
    chk("ign_cout", cout8, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("ign_hold", {busy8, done8, cout8, sum8}, {3'b000, 8'h30});

    // back-to-back: new start raised in the done cycle
    op8(8'h01, 8'h02, 1'b0, lat, bc);
    chk("b2b_first", {cout8, sum8}, 9'h003);
    a8 = 8'h40; b8 = 8'h40; cin8 = 0; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    chk("b2b_busy", {busy8, done8}, 2'b10);
    chk("b2b_holdsum", sum8, 8'h03);
    wait_done8(gap);
    chk("b2b_gap", gap + 1, 9);
    chk("b2b_sum", {cout8, sum8}, 9'h080);

    // reset mid-RUN discards everything
    a8 = 8'hC3; b8 = 8'h3C; cin8 = 1; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("abort_out", {busy8, done8, cout8, sum8}, 11'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_idle", {busy8, done8, cout8, sum8}, 11'h0);

    for (int i = 0; i < 512; i++) begin
      a4 = i[3:0]; b4 = i[7:4]; cin4 = i[8]; start4 = 1;
      exp4 = {1'b0, a4} + {1'b0, b4} + {4'b0, cin4};
      @(posedge clk); #1;
      start4 = 0;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
        @(posedge clk); #1;
        if (done4) begin lat = k; break; end
      end
      chk($sformatf("w4_%0d_lat", i), lat, 4);
      chk($sformatf("w4_%0d_sum", i), {cout4, sum4}, exp4);
    end

    chk("busy_done_excl", both_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
